// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and counter width for the raster
// generator and every block that consumes its h/v counters.
package vga_timing_pkg;
  localparam int CNT_W = 10;

  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;

  localparam int H_TOTAL = H_SYNC_D + H_BP_D + H_ACTIVE_D + H_FP_D;
  localparam int V_TOTAL = V_SYNC_D + V_BP_D + V_ACTIVE_D + V_FP_D;

  // Active window bounds in raw counter space: [START, END)
  localparam int H_ACT_START = H_SYNC_D + H_BP_D;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE_D;
  localparam int V_ACT_START = V_SYNC_D + V_BP_D;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE_D;
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/active decodes of the
// value the counter is about to take, so the parent can register them in step.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int ACTIVE = 640,
  parameter int FP     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic             wrap,
  output logic             sync_n,
  output logic             active
);
  localparam int TOTAL = SYNC + BP + ACTIVE + FP;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] A_START  = CNT_W'(SYNC + BP);
  localparam logic [CNT_W-1:0] A_END    = CNT_W'(SYNC + BP + ACTIVE);

  assign wrap = adv && (count == LAST);

  always_comb begin
    count_nxt = count;
    if (adv) count_nxt = (count == LAST) ? '0 : count + 1'b1;
  end

  assign sync_n = (count_nxt >= SYNC_END);
  assign active = (count_nxt >= A_START) && (count_nxt < A_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= count_nxt;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster source: clk/2 pixel clock, h/v counters including sync and porch,
// registered sync/blank/pixel decodes aligned with the counters, line/frame ticks.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] h_counter,
  output logic [CNT_W-1:0] v_counter,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             VGA_CLK,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             VGA_SYNC_N,
  output logic             line_tick,
  output logic             frame_tick
);
  localparam logic [CNT_W-1:0] H_OFF = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_OFF = CNT_W'(V_SYNC + V_BP);

  logic             div;
  logic             pix_en;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, v_wrap;
  logic             h_sync_n, v_sync_n;
  logic             h_act, v_act, act_nxt;

  assign pix_en = div;

  vga_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP)) u_h (
    .clk(clk), .reset(reset), .adv(pix_en),
    .count(h_counter), .count_nxt(h_nxt), .wrap(h_wrap),
    .sync_n(h_sync_n), .active(h_act)
  );

  // Vertical axis steps only on the horizontal wrap, so its wrap implies a frame end.
  vga_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP)) u_v (
    .clk(clk), .reset(reset), .adv(h_wrap),
    .count(v_counter), .count_nxt(v_nxt), .wrap(v_wrap),
    .sync_n(v_sync_n), .active(v_act)
  );

  assign act_nxt    = h_act && v_act;
  assign VGA_CLK    = div;
  assign VGA_SYNC_N = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div         <= 1'b0;
      VGA_HS      <= 1'b0;
      VGA_VS      <= 1'b0;
      VGA_BLANK_N <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      div         <= ~div;
      VGA_HS      <= h_sync_n;
      VGA_VS      <= v_sync_n;
      VGA_BLANK_N <= act_nxt;
      pixel_x     <= act_nxt ? h_nxt - H_OFF : '0;
      pixel_y     <= act_nxt ? v_nxt - V_OFF : '0;
      line_tick   <= h_wrap;
      frame_tick  <= v_wrap;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster so whole frames fit in a short run.
module tb_vga_timing_gen;
  localparam int HS = 8, HBP = 6, HA = 20, HFP = 4;
  localparam int VS = 2, VBP = 3, VA = 10, VFP = 2;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int HAS = HS + HBP, HAE = HAS + HA;
  localparam int VAS = VS + VBP, VAE = VAS + VA;
  localparam int FRAME_CLK = 2 * HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [9:0] h_counter, v_counter, pixel_x, pixel_y;
  logic VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, line_tick, frame_tick;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP)
  ) dut (
    .clk(clk), .reset(reset),
    .h_counter(h_counter), .v_counter(v_counter),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .line_tick(line_tick), .frame_tick(frame_tick)
  );

  int total = 0;
  int bad = 0;
  int nprint = 0;
  logic [45:0] sb_q[$];

  function automatic logic [45:0] expect_vec(int h, int v, bit d, bit lt, bit ft);
    bit blank;
    int px, py;
    blank = (h >= HAS) && (h < HAE) && (v >= VAS) && (v < VAE);
    px = blank ? h - HAS : 0;
    py = blank ? v - VAS : 0;
    return {10'(h), 10'(v), 10'(px), 10'(py), d, (h >= HS), (v >= VS), blank, lt, ft};
  endfunction

  // Reference raster: pushes the expected output vector after every clock or reset event.
  initial begin : model
    int m_h, m_v;
    bit m_div, w, ft;
    m_h = 0; m_v = 0; m_div = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_h = 0; m_v = 0; m_div = 0;
        sb_q.delete();
        sb_q.push_back(expect_vec(0, 0, 0, 0, 0));
      end else begin
        w = m_div && (m_h == HT - 1);
        ft = 0;
        if (m_div) begin
          if (w) begin
            m_h = 0;
            if (m_v == VT - 1) begin m_v = 0; ft = 1; end
            else m_v = m_v + 1;
          end else m_h = m_h + 1;
        end
        m_div = !m_div;
        sb_q.push_back(expect_vec(m_h, m_v, m_div, w, ft));
      end
    end
  end

  initial begin : checker_p
    logic [45:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        act_v = {h_counter, v_counter, pixel_x, pixel_y, VGA_CLK, VGA_HS, VGA_VS,
                 VGA_BLANK_N, line_tick, frame_tick};
        total++;
        if (act_v !== exp_v) begin
          bad++;
          if (nprint < 20) $display("FAIL scoreboard t=%0t got=%h want=%h", $time, act_v, exp_v);
          nprint++;
        end
      end
      total++;
      if (VGA_SYNC_N !== 1'b0 || h_counter >= 10'(HT) || v_counter >= 10'(VT)) begin
        bad++;
        if (nprint < 20)
          $display("FAIL sync_range got sync_n=%b h=%0d v=%0d want sync_n=0 h<%0d v<%0d",
                   VGA_SYNC_N, h_counter, v_counter, HT, VT);
        nprint++;
      end
    end
  end

  task automatic wait_tick(input bit frame, input int v_want, output bit ok);
    ok = 0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (line_tick && (!frame || frame_tick) && (v_want < 0 || v_counter == 10'(v_want))) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if ({h_counter, v_counter, pixel_x, pixel_y, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
         line_tick, frame_tick} !== 46'd0) begin
      bad++; $display("FAIL reset_values got h=%0d v=%0d clk=%b want all zero", h_counter, v_counter, VGA_CLK);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (h_counter !== 10'd0 || VGA_CLK !== 1'b1 || line_tick !== 1'b0) begin
      bad++; $display("FAIL release_edge1 got h=%0d clk=%b lt=%b want h=0 clk=1 lt=0", h_counter, VGA_CLK, line_tick);
    end
    @(posedge clk); #1;
    total++;
    if (h_counter !== 10'd1 || VGA_CLK !== 1'b0) begin
      bad++; $display("FAIL release_edge2 got h=%0d clk=%b want h=1 clk=0", h_counter, VGA_CLK);
    end
    @(posedge clk); #1;
    total++;
    if (h_counter !== 10'd1 || VGA_CLK !== 1'b1) begin
      bad++; $display("FAIL release_edge3 got h=%0d clk=%b want h=1 clk=1", h_counter, VGA_CLK);
    end
  endtask

  task automatic test_line();
    bit ok;
    int n_hs, n_lt, n_bn, hmax;
    n_hs = 0; n_lt = 0; n_bn = 0; hmax = 0;
    wait_tick(0, 1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL line_wait got timeout want line_tick with v=1"); end
    for (int i = 0; i < 2 * HT; i++) begin
      if (!VGA_HS) n_hs++;
      if (line_tick) n_lt++;
      if (VGA_BLANK_N) n_bn++;
      if (int'(h_counter) > hmax) hmax = int'(h_counter);
      @(negedge clk);
    end
    total++;
    if (n_hs != 2 * HS) begin bad++; $display("FAIL line_hs_width got %0d want %0d", n_hs, 2 * HS); end
    total++;
    if (n_lt != 1) begin bad++; $display("FAIL line_tick_count got %0d want 1", n_lt); end
    total++;
    if (n_bn != 0) begin bad++; $display("FAIL line_blank got %0d want 0", n_bn); end
    total++;
    if (hmax != HT - 1) begin bad++; $display("FAIL line_hmax got %0d want %0d", hmax, HT - 1); end
    total++;
    if (line_tick !== 1'b1 || v_counter !== 10'd2 || h_counter !== 10'd0) begin
      bad++; $display("FAIL line_next got lt=%b v=%0d h=%0d want lt=1 v=2 h=0", line_tick, v_counter, h_counter);
    end
  endtask

  task automatic test_active();
    bit ok, prev;
    int rise_h, rise_px, last_h, last_px, fall_h, py;
    rise_h = -1; rise_px = -1; last_h = -1; last_px = -1; fall_h = -1; py = -1; prev = 0;
    wait_tick(0, VAS + 2, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL active_wait got timeout want line_tick with v=%0d", VAS + 2); end
    for (int i = 0; i < 2 * HT; i++) begin
      if (VGA_BLANK_N && !prev) begin rise_h = int'(h_counter); rise_px = int'(pixel_x); end
      if (!VGA_BLANK_N && prev) fall_h = int'(h_counter);
      if (VGA_BLANK_N) begin last_h = int'(h_counter); last_px = int'(pixel_x); py = int'(pixel_y); end
      prev = VGA_BLANK_N;
      @(negedge clk);
    end
    total++;
    if (rise_h != HAS || rise_px != 0) begin
      bad++; $display("FAIL blank_rise got h=%0d px=%0d want h=%0d px=0", rise_h, rise_px, HAS);
    end
    total++;
    if (last_h != HAE - 1 || last_px != HA - 1) begin
      bad++; $display("FAIL active_last got h=%0d px=%0d want h=%0d px=%0d", last_h, last_px, HAE - 1, HA - 1);
    end
    total++;
    if (fall_h != HAE) begin bad++; $display("FAIL blank_fall got h=%0d want %0d", fall_h, HAE); end
    total++;
    if (py != 2) begin bad++; $display("FAIL pixel_y got %0d want 2", py); end
  endtask

  task automatic test_frame();
    bit ok;
    int n_vs, n_lt, n_ft;
    n_vs = 0; n_lt = 0; n_ft = 0;
    wait_tick(1, 0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL frame_wait got timeout want frame_tick"); end
    for (int i = 0; i < FRAME_CLK; i++) begin
      if (!VGA_VS) n_vs++;
      if (line_tick) n_lt++;
      if (frame_tick) n_ft++;
      @(negedge clk);
    end
    total++;
    if (n_vs != 2 * HT * VS) begin bad++; $display("FAIL vs_width got %0d want %0d", n_vs, 2 * HT * VS); end
    total++;
    if (n_lt != VT) begin bad++; $display("FAIL line_ticks_per_frame got %0d want %0d", n_lt, VT); end
    total++;
    if (n_ft != 1) begin bad++; $display("FAIL frame_ticks_per_frame got %0d want 1", n_ft); end
    total++;
    if (frame_tick !== 1'b1 || line_tick !== 1'b1) begin
      bad++; $display("FAIL frame_period got ft=%b lt=%b want ft=1 lt=1", frame_tick, line_tick);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int n;
    ok = 0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (h_counter == 10'(HT / 2) && v_counter == 10'(VT / 2)) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL midreset_wait got timeout want h=%0d v=%0d", HT / 2, VT / 2); end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    total++;
    if ({h_counter, v_counter, pixel_x, pixel_y, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
         line_tick, frame_tick} !== 46'd0) begin
      bad++; $display("FAIL async_reset got h=%0d v=%0d clk=%b want all zero", h_counter, v_counter, VGA_CLK);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    ok = 0;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      @(posedge clk); #1;
      n++;
      if (frame_tick) begin ok = 1; break; end
    end
    total++;
    if (!ok || n != FRAME_CLK) begin
      bad++; $display("FAIL frame_after_reset got %0d clk (seen=%0d) want %0d", n, ok, FRAME_CLK);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_active();
    test_frame();
    test_mid_reset();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
